scan_ctrl: RTL and testbench

Scan-chain controller that drives the `Test`, `Load` and `SDI` inputs of a chain of scan-mux/flip-flop cells and collects the chain's serial output. A `Start` pulse runs one complete scan test: shift a pattern in, take one functional capture, shift the captured state out. The block sits directly upstream of the scan-mux cells and also receives the tail of the chain (`SDO`). In functional mode it passes the register-load strobe through to the chain unchanged.

---
 rtl/scan_pkg.sv | 14 +
 rtl/scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_scan_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and limits for the scan-chain controller.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } scan_state_t;

  localparam int SCAN_MAX_LEN = 64;

endpackage

// File: rtl/scan_ctrl.sv
// Scan-chain controller: shifts a pattern into the chain, takes one functional
// capture, then shifts the captured chain state back out into Result.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | functional mode, Load follows FuncLoad, waits for Start
// SHIFT_IN  | Test=1, pattern bits driven on SDI, CHAIN_LEN cycles
// CAPTURE   | Test=0, Load=1 for one cycle: chain takes its functional D
// SHIFT_OUT | Test=1, SDO sampled into the result shifter, CHAIN_LEN cycles
// DONE      | one-cycle Done pulse, Result valid, chain back in functional mode
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [CHAIN_LEN-1:0] PatIn,
  input  logic                 FuncLoad,
  input  logic                 SDO,
  output logic                 Test,
  output logic                 Load,
  output logic                 SDI,
  output logic                 Busy,
  output logic                 Done,
  output logic [CHAIN_LEN-1:0] Result
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  scan_state_t          state, state_n;
  logic [CHAIN_LEN-1:0] pat, pat_n;
  logic [CHAIN_LEN-1:0] res, res_n;
  logic [CHAIN_LEN-1:0] result_q, result_n;
  logic [CNT_W-1:0]     cnt, cnt_n;

  // Chain controls are registered so the scan cells never see decode glitches.
  // pass_q marks IDLE/DONE, where the functional load strobe is passed through.
  logic test_q, test_n;
  logic sdi_q, sdi_n;
  logic busy_q, busy_n;
  logic done_q, done_n;
  logic cap_q, cap_n;
  logic pass_q, pass_n;

  // State, datapath and registered chain controls; reset aborts at once.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      pat      <= '0;
      res      <= '0;
      result_q <= '0;
      cnt      <= '0;
      test_q   <= 1'b0;
      sdi_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cap_q    <= 1'b0;
      pass_q   <= 1'b1;
    end else begin
      state    <= state_n;
      pat      <= pat_n;
      res      <= res_n;
      result_q <= result_n;
      cnt      <= cnt_n;
      test_q   <= test_n;
      sdi_q    <= sdi_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      cap_q    <= cap_n;
      pass_q   <= pass_n;
    end
  end

  // Next-state, datapath updates, and the control values for the next state.
  always_comb begin
    state_n  = state;
    pat_n    = pat;
    res_n    = res;
    result_n = result_q;
    cnt_n    = cnt;

    case (state)
      IDLE: begin
        if (Start) begin
          state_n = SHIFT_IN;
          pat_n   = PatIn;
          cnt_n   = '0;
        end
      end
      SHIFT_IN: begin
        pat_n = pat >> 1;
        if (cnt == CNT_LAST) begin
          state_n = CAPTURE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      CAPTURE: begin
        state_n = SHIFT_OUT;
        cnt_n   = '0;
      end
      SHIFT_OUT: begin
        // First sample is the last cell's captured value and ends in bit 0.
        res_n = {SDO, res[CHAIN_LEN-1:1]};
        if (cnt == CNT_LAST) begin
          state_n  = DONE;
          cnt_n    = '0;
          result_n = res_n;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // SDI always mirrors pat[0] while shifting in, so register pat_n[0].
    test_n = (state_n == SHIFT_IN) || (state_n == SHIFT_OUT);
    sdi_n  = (state_n == SHIFT_IN) && pat_n[0];
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
    cap_n  = (state_n == CAPTURE);
    pass_n = (state_n == IDLE) || (state_n == DONE);
  end

  assign Test   = test_q;
  assign SDI    = sdi_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;
  assign Load   = cap_q | (pass_q & FuncLoad);

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl with an 8-cell scan-mux/DFF chain. Cell 0 sits next to
// SDO; SDI feeds cell 7, so the first bit shifted in ends up next to SDO.
module tb_scan_ctrl;
  localparam int N = 8;

  logic         Clock, Reset, Start, FuncLoad;
  logic [N-1:0] PatIn;
  logic         SDO, Test, Load, SDI, Busy, Done;
  logic [N-1:0] Result;

  logic [N-1:0] q, mux_o, d_func, chain_d;
  logic         hold;

  int total = 0;
  int bad = 0;
  logic [N-1:0] prev_result;

  scan_ctrl #(.CHAIN_LEN(N)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .PatIn(PatIn),
    .FuncLoad(FuncLoad), .SDO(SDO), .Test(Test), .Load(Load), .SDI(SDI),
    .Busy(Busy), .Done(Done), .Result(Result)
  );

  // Chain under test: scan mux in front of each DFF.
  assign chain_d = hold ? q : d_func;
  assign SDO     = q[0];
  for (genvar j = 0; j < N; j++) begin : g_cell
    if (j == N - 1) begin : g_head
      assign mux_o[j] = Test ? SDI : (Load ? chain_d[j] : q[j]);
    end else begin : g_body
      assign mux_o[j] = Test ? q[j+1] : (Load ? chain_d[j] : q[j]);
    end
    always_ff @(posedge Clock) q[j] <= mux_o[j];
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One full scan run; optionally pokes Start during SHIFT_OUT and DONE.
  task automatic run_one(input string tag, input logic [N-1:0] pat_v, input logic hold_v,
                         input logic [N-1:0] d_v, input logic [N-1:0] exp_v, input bit poke);
    int done_cyc = 0, done_cnt = 0, test_cnt = 0, busy_cnt = 0;
    int load_cyc = 0, load_cnt = 0, held_bad = 0;
    logic [N-1:0] res_at_done = '0;
    @(negedge Clock);
    hold = hold_v; d_func = d_v; PatIn = pat_v; Start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge Clock);
      Start = poke && (c == 12 || c == 18);
      if (Test) test_cnt++;
      if (Busy) busy_cnt++;
      if (Load) begin load_cnt++; load_cyc = c; end
      if (Done) begin done_cnt++; done_cyc = c; res_at_done = Result; end
      if (c <= 17 && Result !== prev_result) held_bad++;
    end
    Start = 1'b0;
    check({tag, " done_cycle"}, done_cyc, 18);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " test_cycles"}, test_cnt, 16);
    check({tag, " busy_cycles"}, busy_cnt, 18);
    check({tag, " load_count"}, load_cnt, 1);
    check({tag, " load_cycle"}, load_cyc, 9);
    check({tag, " result_at_done"}, res_at_done, exp_v);
    check({tag, " result_held_after"}, Result, exp_v);
    check({tag, " result_held_before"}, held_bad, 0);
    prev_result = exp_v;
  endtask

  typedef struct {
    string        name;
    logic [N-1:0] pat;
    logic         hold;
    logic [N-1:0] d;
    logic [N-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int dcyc[$];
    int c;

    vecs[0] = '{"rt_a5", 8'hA5, 1'b1, 8'h00, 8'hA5};
    vecs[1] = '{"cap_3c", 8'hFF, 1'b0, 8'h3C, 8'h3C};
    vecs[2] = '{"rt_00", 8'h00, 1'b1, 8'hFF, 8'h00};
    vecs[3] = '{"rt_80", 8'h80, 1'b1, 8'h00, 8'h80};
    vecs[4] = '{"rt_01", 8'h01, 1'b1, 8'h00, 8'h01};
    vecs[5] = '{"cap_c3", 8'h5A, 1'b0, 8'hC3, 8'hC3};

    Reset = 1'b1; Start = 1'b0; FuncLoad = 1'b0; PatIn = '0;
    hold = 1'b1; d_func = '0; prev_result = '0;

    // Reset values, checked before any clock edge.
    #2;
    check("rst_test", Test, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_sdi", SDI, 0);
    check("rst_result", Result, 0);
    FuncLoad = 1'b1; #1;
    check("rst_load_follow_hi", Load, 1);
    FuncLoad = 1'b0; #1;
    check("rst_load_follow_lo", Load, 0);
    @(negedge Clock); @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    FuncLoad = 1'b1; #1;
    check("idle_load_follow_hi", Load, 1);
    FuncLoad = 1'b0; #1;
    check("idle_load_follow_lo", Load, 0);

    foreach (vecs[i]) run_one(vecs[i].name, vecs[i].pat, vecs[i].hold, vecs[i].d, vecs[i].exp, 1'b0);

    // Start pulses in SHIFT_OUT and in DONE must be ignored.
    run_one("ignored_start", 8'h96, 1'b1, 8'h00, 8'h96, 1'b1);

    // Abort with reset mid SHIFT_IN.
    @(negedge Clock);
    hold = 1'b1; PatIn = 8'hFF; Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
    @(negedge Clock); @(negedge Clock);
    check("abort_busy_before", Busy, 1);
    #2 Reset = 1'b1;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_test", Test, 0);
    check("abort_result", Result, 0);
    check("abort_done", Done, 0);
    @(negedge Clock);
    check("abort_test_hold", Test, 0);
    Reset = 1'b0;
    prev_result = '0;
    for (c = 0; c < 3; c++) begin
      @(negedge Clock);
      check("abort_no_done", Done, 0);
      check("abort_no_busy", Busy, 0);
    end
    run_one("after_abort", 8'h01, 1'b1, 8'h00, 8'h01, 1'b0);

    // Back-to-back: Start held high continuously.
    @(negedge Clock);
    hold = 1'b1; PatIn = 8'hA5; Start = 1'b1;
    for (c = 1; c <= 60; c++) begin
      @(negedge Clock);
      if (Done) begin
        dcyc.push_back(c);
        check("b2b_result", Result, 8'hA5);
      end
    end
    Start = 1'b0;
    check("b2b_done_count", dcyc.size(), 3);
    if (dcyc.size() == 3) begin
      check("b2b_first_done", dcyc[0], 18);
      check("b2b_period_1", dcyc[1] - dcyc[0], 19);
      check("b2b_period_2", dcyc[2] - dcyc[1], 19);
    end
    c = 0;
    while (Busy && c < 40) begin
      @(negedge Clock);
      c++;
    end
    check("b2b_returns_idle", Busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
